// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline stage register.
// The PIPE_SKID_EN build makes use of the ST_SKID state.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  localparam int PIPE_WIDTH_DEF = 32;
  localparam int PIPE_CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_reg_en.sv
// WIDTH-bit enable register with async active-low clear and a synchronous
// load-of-RESET_VAL input that takes priority over the enable.
module pipe_reg_en
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = PIPE_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_load_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_q <= RESET_VAL;
    end else if (i_load_rst) begin
      r_q <= RESET_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and stall counter.
// Define PIPE_SKID_EN to add a skid entry and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = PIPE_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = PIPE_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  pipe_state_e      r_state;
  pipe_state_e      w_state_nxt;
  logic             w_main_en;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [CNT_W-1:0] r_stall_cnt;

  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = w_main_q;
  assign stall_cnt  = r_stall_cnt;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

`ifdef PIPE_SKID_EN
  logic             w_skid_en;
  logic             w_main_sel_skid;
  logic [WIDTH-1:0] w_skid_q;
  logic             r_in_ready;

  // in_ready is registered from the next state so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_state_nxt != ST_SKID);
    end
  end

  assign in_ready = r_in_ready;
  assign w_main_d = w_main_sel_skid ? w_skid_q : in_data;

  pipe_reg_en #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk        (clk),
    .clr        (clr),
    .i_load_rst (flush),
    .i_en       (w_skid_en),
    .i_d        (in_data),
    .o_q        (w_skid_q)
  );
`else
  assign in_ready = !out_valid || out_ready;
  assign w_main_d = in_data;
`endif

  pipe_reg_en #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk        (clk),
    .clr        (clr),
    .i_load_rst (flush),
    .i_en       (w_main_en),
    .i_d        (w_main_d),
    .o_q        (w_main_q)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_en   = 1'b0;
`ifdef PIPE_SKID_EN
    w_skid_en       = 1'b0;
    w_main_sel_skid = 1'b0;
`endif
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = ST_BUSY;
          w_main_en   = 1'b1;
        end
      end
      ST_BUSY: begin
        if (w_in_xfer && w_out_xfer) begin
          w_main_en = 1'b1;
`ifdef PIPE_SKID_EN
        end else if (w_in_xfer) begin
          w_state_nxt = ST_SKID;
          w_skid_en   = 1'b1;
`endif
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
`ifdef PIPE_SKID_EN
      ST_SKID: begin
        if (out_ready) begin
          w_state_nxt     = ST_BUSY;
          w_main_en       = 1'b1;
          w_main_sel_skid = 1'b1;
        end
      end
`endif
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush wins; the payload registers reload RESET_VAL through i_load_rst
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; adapts its in_ready expectation to
// whether PIPE_SKID_EN is defined.
module tb_pipe_stage_reg;

  localparam int             W    = 32;
  localparam int             CW   = 3;
  localparam logic [W-1:0]   RST  = 32'h0000_0001;
  localparam logic [CW-1:0]  SMAX = {CW{1'b1}};
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] stall_cnt;

  int            n_chk = 0;
  int            n_pass = 0;
  int            n_out = 0;
  logic [W-1:0]  q[$];
  logic [CW-1:0] exp_stall = '0;
  bit            last_in_x = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .WIDTH     (W),
    .RESET_VAL (RST),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Check outputs at the falling edge, then advance the model across the rising edge.
  task automatic tick();
    bit           exp_vld, exp_rdy, out_x, in_x, st_inc, fl;
    logic [W-1:0] d;
    @(negedge clk);
    exp_vld = (q.size() != 0);
    exp_rdy = SKID ? (q.size() < 2) : (!exp_vld || out_ready);
    chk("out_valid", out_valid, exp_vld);
    if (exp_vld) chk("out_data", out_data, q[0]);
    chk("in_ready", in_ready, exp_rdy);
    chk("stall_cnt", stall_cnt, exp_stall);
    out_x  = exp_vld && out_ready;
    in_x   = in_valid && exp_rdy && !flush;
    st_inc = exp_vld && !out_ready;
    fl     = flush;
    d      = in_data;
    @(posedge clk);
    if (out_x) begin
      void'(q.pop_front());
      n_out++;
    end
    if (fl) q.delete();
    else if (in_x) q.push_back(d);
    if (st_inc && exp_stall != SMAX) exp_stall = exp_stall + 1'b1;
    last_in_x = in_x;
    #1;
    if (in_x) in_valid = 1'b0;
  endtask

  // Entered one unit after a rising edge; pulls clr low between edges.
  task automatic async_reset();
    #2;
    clr = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    chk("rst_out_data", out_data, RST);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_stall", stall_cnt, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    q.delete();
    exp_stall = '0;
    @(posedge clk);
    #3;
    clr = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    #1;
    async_reset();

    // streaming, one per cycle
    out_ready = 1'b1;
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h10 + i;
      tick();
    end
    repeat (3) tick();
    chk("stream_count", n_out - base, 8);

    // back-pressure then release
    out_ready = 1'b0;
    base = n_out;
    in_valid = 1'b1; in_data = 32'hA; tick();
    in_valid = 1'b1; in_data = 32'hB;
    repeat (3) tick();
    chk("bp_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("bp_count", n_out - base, 2);

    // flush while holding A (and B in skid build), with C offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; tick();
    in_valid = 1'b1; in_data = 32'hB; tick();
    in_valid = 1'b1; in_data = 32'hC; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_data", out_data, RST);
    out_ready = 1'b1;
    repeat (3) tick();

    // flush with in_valid while empty
    in_valid = 1'b1; in_data = 32'hC; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_empty_valid", out_valid, 1'b0);
    tick();

    // flush in BUSY with a completing out transfer
    in_valid = 1'b1; in_data = 32'h33; tick();
    in_valid = 1'b1; in_data = 32'h44; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    tick();

    // in_ready response to out_ready while BUSY
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h55; tick();
    out_ready = 1'b0;
    #1 chk("rdy_comb_lo", in_ready, SKID);
    out_ready = 1'b1;
    #1 chk("rdy_comb_hi", in_ready, 1'b1);
    repeat (2) tick();

    // stall counter saturation, unaffected by flush
    async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h77; tick();
    repeat (10) tick();
    chk("stall_sat", stall_cnt, SMAX);
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("stall_after_flush", stall_cnt, SMAX);
    tick();

    // reset while payloads are held
    in_valid = 1'b1; in_data = 32'h88; tick();
    in_valid = 1'b1; in_data = 32'h99; tick();
    async_reset();
    out_ready = 1'b1;
    repeat (3) tick();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid) begin
        in_valid = $urandom_range(0, 1);
        in_data  = $urandom;
      end
      flush = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("final_valid", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
